// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a first-word-fall-through FIFO built around an external mem.
// Generates gated write/read strobes, pointers, occupancy flags and sticky error bits.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2 ** ADDR_WIDTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic                  w_ena,
  output logic                  r_ena,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = CW'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] C_AE    = CW'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] C_ONE   = CW'(1);

  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic [ADDR_WIDTH:0] r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic [ADDR_WIDTH:0] w_wptr_nxt;
  logic [ADDR_WIDTH:0] w_rptr_nxt;
  logic [ADDR_WIDTH:0] w_count_nxt;
  logic                w_overflow_nxt;
  logic                w_underflow_nxt;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ok;
  logic                w_pop_ok;

  // Flags come from the occupancy counter alone, so full and empty are never ambiguous.
  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_push_ok = push & ~w_full;
  assign w_pop_ok  = pop & ~w_empty;

  always_comb begin
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_count_nxt     = r_count;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;

    if (w_push_ok) begin
      w_wptr_nxt = r_wptr + C_ONE;
    end else begin
      w_wptr_nxt = r_wptr;
    end

    if (w_pop_ok) begin
      w_rptr_nxt = r_rptr + C_ONE;
    end else begin
      w_rptr_nxt = r_rptr;
    end

    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase

    // A fresh error in the same cycle as clr_err wins, so no event is ever lost.
    if (push & w_full) begin
      w_overflow_nxt = 1'b1;
    end else if (clr_err) begin
      w_overflow_nxt = 1'b0;
    end else begin
      w_overflow_nxt = r_overflow;
    end

    if (pop & w_empty) begin
      w_underflow_nxt = 1'b1;
    end else if (clr_err) begin
      w_underflow_nxt = 1'b0;
    end else begin
      w_underflow_nxt = r_underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= {CW{1'b0}};
      r_rptr      <= {CW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  assign w_ena        = w_push_ok;
  assign r_ena        = w_pop_ok;
  assign w_addr       = r_wptr[ADDR_WIDTH-1:0];
  assign r_addr       = r_rptr[ADDR_WIDTH-1:0];
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural FWFT memory attached to its strobes.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic       w_ena;
  logic       r_ena;
  logic [4:0] w_addr;
  logic [4:0] r_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [5:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [7:0] mem [32];

  int n_cmp;
  int n_err;

  fifo_ctrl #(.ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
    .w_ena(w_ena), .r_ena(r_ena), .w_addr(w_addr), .r_addr(r_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_ena) mem[w_addr] <= w_data;
  end
  assign r_data = mem[r_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; w_data = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 6'd0) begin
      n_err++;
      $display("FAIL reset_flags got empty=%b full=%b count=%0d want 1 0 0", empty, full, count);
    end
    n_cmp++;
    if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_almost got ae=%b af=%b want 1 0", almost_empty, almost_full);
    end
    n_cmp++;
    if (w_addr !== 5'd0 || r_addr !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ptrs got wa=%0d ra=%0d ovf=%b unf=%b want 0 0 0 0",
               w_addr, r_addr, overflow, underflow);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      push = 1'b1; w_data = 8'(i);
      #1;
      n_cmp++;
      if (w_ena !== 1'b1 || almost_full !== (i >= 28)) begin
        n_err++;
        $display("FAIL fill_strobe i=%0d got w_ena=%b af=%b want 1 %b", i, w_ena, almost_full, (i >= 28));
      end
      step();
      n_cmp++;
      if (count !== 6'(i + 1)) begin
        n_err++;
        $display("FAIL fill_count i=%0d got %0d want %0d", i, count, i + 1);
      end
    end
    n_cmp++;
    if (full !== 1'b1 || almost_full !== 1'b1 || empty !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full got full=%b af=%b empty=%b want 1 1 0", full, almost_full, empty);
    end
    push = 1'b1; w_data = 8'hEE;
    #1;
    n_cmp++;
    if (w_ena !== 1'b0) begin
      n_err++;
      $display("FAIL fill_extra_wena got %b want 0", w_ena);
    end
    step();
    idle_inputs();
    n_cmp++;
    if (overflow !== 1'b1 || count !== 6'd32 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL fill_overflow got ovf=%b count=%0d unf=%b want 1 32 0", overflow, count, underflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      pop = 1'b1;
      #1;
      n_cmp++;
      if (r_ena !== 1'b1 || r_data !== 8'(i)) begin
        n_err++;
        $display("FAIL drain_data i=%0d got r_ena=%b r_data=%h want 1 %h", i, r_ena, r_data, 8'(i));
      end
      step();
      n_cmp++;
      if (count !== 6'(31 - i) || almost_empty !== ((31 - i) <= 4)) begin
        n_err++;
        $display("FAIL drain_count i=%0d got count=%0d ae=%b want %0d %b",
                 i, count, almost_empty, 31 - i, ((31 - i) <= 4));
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty got empty=%b full=%b want 1 0", empty, full);
    end
    pop = 1'b1;
    #1;
    n_cmp++;
    if (r_ena !== 1'b0) begin
      n_err++;
      $display("FAIL drain_extra_rena got %b want 0", r_ena);
    end
    step();
    idle_inputs();
    n_cmp++;
    if (underflow !== 1'b1 || count !== 6'd0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL drain_underflow got unf=%b count=%0d ovf=%b want 1 0 1", underflow, count, overflow);
    end
  endtask

  task automatic test_clr_err();
    clr_err = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL clr_both got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
    clr_err = 1'b1; pop = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clr_vs_underflow got unf=%b ovf=%b want 1 0", underflow, overflow);
    end
    clr_err = 1'b1;
    step();
    idle_inputs();
  endtask

  // Pointers start at low bits 0 here, so 40 words cross the 31->0 wrap.
  task automatic test_wrap();
    push = 1'b1; w_data = 8'hA0;
    step();
    for (int k = 1; k < 40; k++) begin
      push = 1'b1; pop = 1'b1; w_data = 8'(8'hA0 + k);
      #1;
      n_cmp++;
      if (r_data !== 8'(8'hA0 + k - 1) || w_addr !== 5'(k % 32) || r_addr !== 5'((k - 1) % 32)) begin
        n_err++;
        $display("FAIL wrap_stream k=%0d got data=%h wa=%0d ra=%0d want %h %0d %0d",
                 k, r_data, w_addr, r_addr, 8'(8'hA0 + k - 1), k % 32, (k - 1) % 32);
      end
      step();
      n_cmp++;
      if (count !== 6'd1) begin
        n_err++;
        $display("FAIL wrap_count k=%0d got %0d want 1", k, count);
      end
    end
    push = 1'b0; pop = 1'b1;
    #1;
    n_cmp++;
    if (r_data !== 8'hC7 || r_addr !== 5'd7) begin
      n_err++;
      $display("FAIL wrap_last got data=%h ra=%0d want c7 7", r_data, r_addr);
    end
    step();
    idle_inputs();
    n_cmp++;
    if (empty !== 1'b1 || w_addr !== 5'd8 || r_addr !== 5'd8) begin
      n_err++;
      $display("FAIL wrap_end got empty=%b wa=%0d ra=%0d want 1 8 8", empty, w_addr, r_addr);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; w_data = 8'(8'h40 + i);
      step();
    end
    push = 1'b1; pop = 1'b1; w_data = 8'h4A;
    #1;
    n_cmp++;
    if (w_ena !== 1'b1 || r_ena !== 1'b1 || r_data !== 8'h40) begin
      n_err++;
      $display("FAIL simul_mid_strobes got w=%b r=%b data=%h want 1 1 40", w_ena, r_ena, r_data);
    end
    step();
    n_cmp++;
    if (count !== 6'd10 || r_data !== 8'h41) begin
      n_err++;
      $display("FAIL simul_mid_count got count=%0d data=%h want 10 41", count, r_data);
    end
    pop = 1'b0;
    for (int i = 0; i < 22; i++) begin
      push = 1'b1; w_data = 8'(8'h4B + i);
      step();
    end
    push = 1'b1; pop = 1'b1; w_data = 8'hFF;
    #1;
    n_cmp++;
    if (full !== 1'b1 || w_ena !== 1'b0 || r_ena !== 1'b1) begin
      n_err++;
      $display("FAIL simul_full_strobes got full=%b w=%b r=%b want 1 0 1", full, w_ena, r_ena);
    end
    step();
    n_cmp++;
    if (count !== 6'd31 || overflow !== 1'b1 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL simul_full_result got count=%0d ovf=%b unf=%b want 31 1 0", count, overflow, underflow);
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 31; i++) step();
    push = 1'b1; pop = 1'b1; w_data = 8'h5A;
    #1;
    n_cmp++;
    if (empty !== 1'b1 || w_ena !== 1'b1 || r_ena !== 1'b0) begin
      n_err++;
      $display("FAIL simul_empty_strobes got empty=%b w=%b r=%b want 1 1 0", empty, w_ena, r_ena);
    end
    step();
    idle_inputs();
    n_cmp++;
    if (count !== 6'd1 || underflow !== 1'b1 || r_data !== 8'h5A) begin
      n_err++;
      $display("FAIL simul_empty_result got count=%0d unf=%b data=%h want 1 1 5a", count, underflow, r_data);
    end
  endtask

  task automatic test_reset_midstream();
    push = 1'b1; w_data = 8'h77;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (count !== 6'd0 || empty !== 1'b1 || w_addr !== 5'd0 || r_addr !== 5'd0) begin
      n_err++;
      $display("FAIL midrst_state got count=%0d empty=%b wa=%0d ra=%0d want 0 1 0 0",
               count, empty, w_addr, r_addr);
    end
    n_cmp++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_errors got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
    idle_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_clr_err();
    test_wrap();
    test_clr_err();
    test_simultaneous();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
